// File: rtl/lt_measure_ctrl_pkg.sv
// Shared definitions for the latency-tester measurement controller:
// FSM state codes, flash position codes and the error result value.
package lt_measure_ctrl_pkg;

  typedef enum logic [1:0] {
    LT_ST_IDLE  = 2'd0,
    LT_ST_ARM   = 2'd1,
    LT_ST_FLASH = 2'd2,
    LT_ST_HOLD  = 2'd3
  } lt_state_t;

  localparam logic [1:0] LT_POS_TOPLEFT     = 2'd0;
  localparam logic [1:0] LT_POS_CENTER      = 2'd1;
  localparam logic [1:0] LT_POS_BOTTOMRIGHT = 2'd2;
  localparam logic [1:0] LT_POS_FULLSCREEN  = 2'd3;

  // Reported in result_us whenever a measurement times out
  localparam logic [15:0] LT_RESULT_ERR = 16'hFFFF;

endpackage

// File: rtl/lt_measure_ctrl_if.sv
// Control/result bundle between the host side and the measurement controller.
interface lt_measure_ctrl_if;
  logic        start;
  logic        abort;
  logic [1:0]  mode_in;
  logic        lt_active;
  logic [1:0]  lt_mode;
  logic        busy;
  logic [15:0] result_us;
  logic        result_valid;
  logic        timeout;

  modport master (
    output start, abort, mode_in,
    input  lt_active, lt_mode, busy, result_us, result_valid, timeout
  );

  modport slave (
    input  start, abort, mode_in,
    output lt_active, lt_mode, busy, result_us, result_valid, timeout
  );
endinterface

// File: rtl/lt_measure_ctrl_sensor_filter.sv
// Photodiode input path: 2-flop synchronizer followed by a run-length glitch
// filter that only accepts a new level after FILT_LEN consecutive samples.
module lt_sensor_filter #(
  parameter int FILT_LEN = 16
) (
  input  logic clk27,
  input  logic reset_n,
  input  logic sensor_n,
  output logic sens_lit
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] run_cnt;
  logic          sample_lit;

  assign sample_lit = ~sync2;

  // Any sample that agrees with the current level breaks the run
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      run_cnt  <= '0;
      sens_lit <= 1'b0;
    end else begin
      sync1 <= sensor_n;
      sync2 <= sync1;
      if (sample_lit == sens_lit) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILT_LEN - 1)) begin
        sens_lit <= sample_lit;
        run_cnt  <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lt_measure_ctrl.sv
// Latency-tester controller: aligns the flash to vsync, times flash-to-light
// in microseconds and reports the result or a timeout.
module lt_measure_ctrl
  import lt_measure_ctrl_pkg::*;
#(
  parameter int          PRESCALE    = 27,
  parameter int          FILT_LEN    = 16,
  parameter logic [15:0] TIMEOUT_US  = 16'd50000,
  parameter logic [7:0]  ARM_FRAMES  = 8'd60,
  parameter logic [7:0]  HOLD_FRAMES = 8'd4
) (
  input  logic             clk27,
  input  logic             reset_n,
  input  logic             vsync_in,
  input  logic             sensor_n,
  lt_measure_ctrl_if.slave ctl
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  lt_state_t   state, state_nx;
  logic        vs_prev, vs_fall, sens_lit;
  logic [PW-1:0] pre_q, pre_nx;
  logic [15:0] us_q, us_nx, result_q, result_nx;
  logic [7:0]  frame_q, frame_nx;
  logic [1:0]  mode_q, mode_nx;
  logic        valid_q, valid_nx, timeout_q, timeout_nx;
  logic        active_q, busy_q;

  lt_sensor_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk27    (clk27),
    .reset_n  (reset_n),
    .sensor_n (sensor_n),
    .sens_lit (sens_lit)
  );

  assign vs_fall = vs_prev & ~vsync_in;

  // frame_q counts lit frames in ARM and elapsed frames in HOLD
  always_comb begin
    state_nx   = state;
    pre_nx     = pre_q;
    us_nx      = us_q;
    frame_nx   = frame_q;
    mode_nx    = mode_q;
    result_nx  = result_q;
    valid_nx   = valid_q;
    timeout_nx = timeout_q;
    if (ctl.abort) begin
      state_nx = LT_ST_IDLE;
    end else begin
      case (state)
        LT_ST_IDLE: if (ctl.start) begin
          mode_nx    = ctl.mode_in;
          valid_nx   = 1'b0;
          timeout_nx = 1'b0;
          frame_nx   = '0;
          state_nx   = LT_ST_ARM;
        end
        LT_ST_ARM: if (vs_fall) begin
          if (!sens_lit) begin
            pre_nx   = '0;
            us_nx    = '0;
            state_nx = LT_ST_FLASH;
          end else if (frame_q == ARM_FRAMES - 8'd1) begin
            timeout_nx = 1'b1;
            result_nx  = LT_RESULT_ERR;
            frame_nx   = '0;
            state_nx   = LT_ST_HOLD;
          end else begin
            frame_nx = frame_q + 8'd1;
          end
        end
        LT_ST_FLASH: begin
          if (pre_q == PW'(PRESCALE - 1)) begin
            pre_nx = '0;
            if (us_q != 16'hFFFF) us_nx = us_q + 16'd1;
          end else begin
            pre_nx = pre_q + 1'b1;
          end
          // Light detection wins over a timeout landing in the same cycle
          if (sens_lit) begin
            result_nx = us_q;
            valid_nx  = 1'b1;
            frame_nx  = '0;
            state_nx  = LT_ST_HOLD;
          end else if (us_q == TIMEOUT_US) begin
            timeout_nx = 1'b1;
            result_nx  = LT_RESULT_ERR;
            frame_nx   = '0;
            state_nx   = LT_ST_HOLD;
          end
        end
        LT_ST_HOLD: if (vs_fall) begin
          if (frame_q == HOLD_FRAMES - 8'd1) state_nx = LT_ST_IDLE;
          else frame_nx = frame_q + 8'd1;
        end
        default: state_nx = LT_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= LT_ST_IDLE;
      vs_prev   <= 1'b1;
      pre_q     <= '0;
      us_q      <= '0;
      frame_q   <= '0;
      mode_q    <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      active_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      vs_prev   <= vsync_in;
      pre_q     <= pre_nx;
      us_q      <= us_nx;
      frame_q   <= frame_nx;
      mode_q    <= mode_nx;
      result_q  <= result_nx;
      valid_q   <= valid_nx;
      timeout_q <= timeout_nx;
      active_q  <= (state_nx == LT_ST_FLASH);
      busy_q    <= (state_nx != LT_ST_IDLE);
    end
  end

  assign ctl.lt_active    = active_q;
  assign ctl.lt_mode      = mode_q;
  assign ctl.busy         = busy_q;
  assign ctl.result_us    = result_q;
  assign ctl.result_valid = valid_q;
  assign ctl.timeout      = timeout_q;

endmodule

// File: tb/tb_lt_measure_ctrl.sv
// Self-checking bench for lt_measure_ctrl: randomized vsync/measurements checked
// every cycle against a cycle-count based reference model, plus literal pins.
module tb_lt_measure_ctrl;
  import lt_measure_ctrl_pkg::*;

  localparam int          P  = 4;
  localparam int          F  = 16;
  localparam logic [15:0] TO = 16'd200;
  localparam int          AF = 5;
  localparam int          HF = 3;

  logic clk27 = 1'b0;
  logic reset_n = 1'b0;
  logic vsync_in = 1'b1;
  logic sensor_n = 1'b1;

  lt_measure_ctrl_if ctl();

  lt_measure_ctrl #(
    .PRESCALE(P), .FILT_LEN(F), .TIMEOUT_US(TO),
    .ARM_FRAMES(8'(AF)), .HOLD_FRAMES(8'(HF))
  ) dut (
    .clk27    (clk27),
    .reset_n  (reset_n),
    .vsync_in (vsync_in),
    .sensor_n (sensor_n),
    .ctl      (ctl)
  );

  always #5 clk27 = ~clk27;

  int checks = 0;
  int errors = 0;

  bit         s_start = 0, s_abort = 0, s_sensor = 1, s_rst = 0;
  logic [1:0] s_mode = 2'd0;
  int         vs_cnt = 0, vs_period = 40;

  typedef enum {M_IDLE, M_WAIT_VS, M_LIGHT, M_COOLDOWN} mphase_t;
  mphase_t     m_phase;
  longint      m_cyc, m_flash_edge;
  int          m_frames;
  bit          m_vs_prev, m_lit, m_valid, m_tmo;
  logic [1:0]  m_mode;
  logic [15:0] m_result;
  bit          raw_q[$];

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void modelReset();
    m_phase = M_IDLE; m_cyc = 0; m_flash_edge = 0; m_frames = 0;
    m_vs_prev = 1; m_lit = 0; m_valid = 0; m_tmo = 0;
    m_mode = 2'd0; m_result = 16'd0;
    raw_q.delete();
    for (int i = 0; i < F + 2; i++) raw_q.push_back(1'b1);
  endfunction

  // Predicts the effect of the coming clock edge from the inputs just driven
  function automatic void modelStep();
    bit     fall, all_diff;
    longint us_now;
    m_cyc++;
    fall = m_vs_prev && !vsync_in;
    m_vs_prev = vsync_in;
    us_now = (m_cyc - 1 - m_flash_edge) / P;
    if (us_now > 65535) us_now = 65535;
    if (s_abort) m_phase = M_IDLE;
    else case (m_phase)
      M_IDLE: if (s_start) begin
        m_mode = s_mode; m_valid = 0; m_tmo = 0; m_frames = 0; m_phase = M_WAIT_VS;
      end
      M_WAIT_VS: if (fall) begin
        if (!m_lit) begin m_phase = M_LIGHT; m_flash_edge = m_cyc; end
        else begin
          m_frames++;
          if (m_frames == AF) begin
            m_tmo = 1; m_result = 16'hFFFF; m_frames = 0; m_phase = M_COOLDOWN;
          end
        end
      end
      M_LIGHT: begin
        if (m_lit) begin
          m_result = 16'(us_now); m_valid = 1; m_frames = 0; m_phase = M_COOLDOWN;
        end else if (us_now == longint'(TO)) begin
          m_tmo = 1; m_result = 16'hFFFF; m_frames = 0; m_phase = M_COOLDOWN;
        end
      end
      M_COOLDOWN: if (fall) begin
        m_frames++;
        if (m_frames == HF) m_phase = M_IDLE;
      end
      default: m_phase = M_IDLE;
    endcase
    // Filter view: synchronized sample is the raw input two edges back
    raw_q.push_back(s_sensor);
    void'(raw_q.pop_front());
    all_diff = 1;
    for (int i = 0; i < F; i++) if (raw_q[i] != m_lit) all_diff = 0;
    if (all_diff) m_lit = !m_lit;
  endfunction

  task automatic checkOutput();
    cmp("lt_active",    16'(ctl.lt_active),    16'(m_phase == M_LIGHT));
    cmp("lt_mode",      16'(ctl.lt_mode),      16'(m_mode));
    cmp("busy",         16'(ctl.busy),         16'(m_phase != M_IDLE));
    cmp("result_us",    ctl.result_us,         m_result);
    cmp("result_valid", 16'(ctl.result_valid), 16'(m_valid));
    cmp("timeout",      16'(ctl.timeout),      16'(m_tmo));
  endtask

  task automatic applyStimulus();
    vs_cnt++;
    if (vs_cnt >= vs_period) begin
      vs_cnt = 0;
      vs_period = $urandom_range(60, 30);
    end
    vsync_in    = (vs_cnt >= 3);
    reset_n     = s_rst;
    sensor_n    = s_sensor;
    ctl.start   = s_start;
    ctl.abort   = s_abort;
    ctl.mode_in = s_mode;
  endtask

  task automatic tick();
    @(negedge clk27);
    checkOutput();
    applyStimulus();
    if (!s_rst) modelReset();
    else modelStep();
    s_start = 0;
    s_abort = 0;
  endtask

  function automatic bit cond(input int what);
    case (what)
      0:       return ctl.lt_active == 1'b1;
      1:       return (ctl.result_valid | ctl.timeout) == 1'b1;
      2:       return ctl.busy == 1'b0;
      default: return ctl.timeout == 1'b1;
    endcase
  endfunction

  task automatic waitFor(input string name, input int what, input int budget, output int n);
    n = 0;
    while (!cond(what) && n < budget) begin
      tick();
      n++;
    end
    if (!cond(what)) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_%s: condition not reached, expected within %0d cycles", name, budget);
    end
  endtask

  task automatic measure(input logic [1:0] mode, input int d);
    int n;
    s_mode = mode; s_start = 1; tick();
    waitFor("active", 0, 400, n);
    repeat (d - 1) tick();
    s_sensor = 0; tick();
    waitFor("done", 1, 200, n);
    s_sensor = 1;
    waitFor("idle", 2, 400, n);
    repeat (20) tick();
  endtask

  initial begin
    int n;
    ctl.start = 0; ctl.abort = 0; ctl.mode_in = 2'd0;
    modelReset();
    repeat (3) tick();
    cmp("reset_lt_active", 16'(ctl.lt_active), 16'd0);
    cmp("reset_busy",      16'(ctl.busy),      16'd0);
    cmp("reset_result",    ctl.result_us,      16'd0);
    s_rst = 1;
    repeat (5) tick();

    // Basic: light 400 cycles after flash + 18-cycle sensor path -> 418/4 = 104 us
    measure(LT_POS_CENTER, 400);
    cmp("basic_result",  ctl.result_us,         16'd104);
    cmp("basic_valid",   16'(ctl.result_valid), 16'd1);
    cmp("basic_timeout", 16'(ctl.timeout),      16'd0);
    cmp("basic_mode",    16'(ctl.lt_mode),      16'(LT_POS_CENTER));

    // Start while busy is ignored; abort mid-flash keeps the result
    s_mode = LT_POS_CENTER; s_start = 1; tick();
    waitFor("abort_active", 0, 400, n);
    repeat (10) tick();
    s_mode = LT_POS_FULLSCREEN; s_start = 1; tick(); tick();
    cmp("busy_start_mode",   16'(ctl.lt_mode),   16'(LT_POS_CENTER));
    cmp("busy_start_active", 16'(ctl.lt_active), 16'd1);
    s_abort = 1; tick(); tick();
    cmp("abort_active", 16'(ctl.lt_active),    16'd0);
    cmp("abort_busy",   16'(ctl.busy),         16'd0);
    cmp("abort_result", ctl.result_us,         16'd104);
    cmp("abort_valid",  16'(ctl.result_valid), 16'd0);
    s_mode = LT_POS_BOTTOMRIGHT; s_start = 1; s_abort = 1; tick(); tick();
    cmp("start_abort_busy", 16'(ctl.busy),    16'd0);
    cmp("start_abort_mode", 16'(ctl.lt_mode), 16'(LT_POS_CENTER));
    repeat (5) tick();

    // Flash timeout: 200 us * 4 cycles, reported one edge later
    s_mode = LT_POS_TOPLEFT; s_start = 1; tick();
    waitFor("to_active", 0, 400, n);
    waitFor("flash_timeout", 3, 1200, n);
    cmp("flash_to_cycles", 16'(n),              16'd801);
    cmp("flash_to_result", ctl.result_us,       16'hFFFF);
    cmp("flash_to_active", 16'(ctl.lt_active),  16'd0);
    waitFor("to_idle", 2, 400, n);

    // Arm timeout: sensor already lit
    s_sensor = 0; repeat (25) tick();
    s_start = 1; tick();
    waitFor("arm_timeout", 3, 600, n);
    cmp("arm_to_result", ctl.result_us,      16'hFFFF);
    cmp("arm_to_active", 16'(ctl.lt_active), 16'd0);
    s_sensor = 1;
    waitFor("arm_idle", 2, 400, n);
    repeat (20) tick();

    // Glitch rejection then a real pulse
    s_mode = LT_POS_CENTER; s_start = 1; tick();
    waitFor("gl_active", 0, 400, n);
    repeat (50) tick();
    s_sensor = 0; repeat (10) tick();
    s_sensor = 1; repeat (60) tick();
    cmp("glitch_valid",  16'(ctl.result_valid), 16'd0);
    cmp("glitch_active", 16'(ctl.lt_active),    16'd1);
    s_sensor = 0; repeat (20) tick();
    s_sensor = 1;
    waitFor("gl_done", 1, 100, n);
    cmp("pulse_valid", 16'(ctl.result_valid), 16'd1);
    waitFor("gl_idle", 2, 400, n);
    repeat (20) tick();

    for (int r = 0; r < 4; r++) measure(2'($urandom_range(3, 0)), $urandom_range(700, 20));

    // Reset mid-flash, then a clean measurement
    s_mode = LT_POS_CENTER; s_start = 1; tick();
    waitFor("rst_active", 0, 400, n);
    repeat (20) tick();
    reset_n = 0; s_rst = 0;
    #1;
    cmp("rst_active", 16'(ctl.lt_active),    16'd0);
    cmp("rst_busy",   16'(ctl.busy),         16'd0);
    cmp("rst_mode",   16'(ctl.lt_mode),      16'd0);
    cmp("rst_result", ctl.result_us,         16'd0);
    cmp("rst_valid",  16'(ctl.result_valid), 16'd0);
    cmp("rst_tmo",    16'(ctl.timeout),      16'd0);
    modelReset();
    repeat (3) tick();
    s_rst = 1; repeat (5) tick();
    measure(LT_POS_BOTTOMRIGHT, 400);
    cmp("post_rst_result", ctl.result_us,    16'd104);
    cmp("post_rst_mode",   16'(ctl.lt_mode), 16'(LT_POS_BOTTOMRIGHT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lt_measure_ctrl.md
# lt_measure_ctrl

Latency-tester measurement controller sitting directly upstream of the test-pattern video generator. It receives a start request and a photodiode sensor input, aligns the test flash to the generator's vertical sync, and drives the generator's `lt_active` and `lt_mode` inputs. It times the interval from flash start to light detection in microseconds, and reports either the result or a timeout.

## Interface

Parameters:
- `PRESCALE`, 27: clk27 cycles per microsecond tick.
- `FILT_LEN`, 16: consecutive identical synchronized sensor samples needed to accept a new sensor level.
- `TIMEOUT_US`, 16'd50000: microsecond count in FLASH at which the measurement is aborted as timed out.
- `ARM_FRAMES`, 8'd60: vsync falling edges allowed in ARM before a dark-sensor timeout.
- `HOLD_FRAMES`, 8'd4: vsync falling edges spent dark in HOLD before returning to IDLE.

Ports:
- `clk27`, in, 1: pixel clock (27 MHz).
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: single-cycle measurement request; ignored unless in IDLE.
- `abort`, in, 1: level; forces IDLE from any state.
- `mode_in`, in, 2: flash position code (LT_POS_* from the shared include); latched on accepted start.
- `vsync_in`, in, 1: generator VSYNC, negative polarity, clk27 domain.
- `sensor_n`, in, 1: photodiode comparator, asynchronous, low = light detected.
- `lt_active`, out, 1: flash enable to the generator.
- `lt_mode`, out, 2: latched flash position to the generator.
- `busy`, out, 1: high in any state other than IDLE.
- `result_us`, out, 16: measured latency in µs.
- `result_valid`, out, 1: `result_us` holds a completed measurement.
- `timeout`, out, 1: last measurement failed (ARM or FLASH timeout).

## Operation

- Sensor path: 2-flop synchronizer, then glitch filter. The filtered level `sens_lit` changes only after `FILT_LEN` consecutive equal samples that differ from the current level. Reset level is dark (`sens_lit` = 0).
- `vs_fall`: registered previous `vsync_in` = 1 and current = 0. Reset previous value is 1.
- State machine: IDLE, ARM, FLASH, HOLD.
  - **IDLE**: on `start`, latch `mode_in` into `lt_mode`, clear `result_valid` and `timeout`, clear frame counter, go to ARM.
  - **ARM**: on `vs_fall` with `sens_lit` = 0, clear the prescaler and µs counter and go to FLASH. On a `vs_fall` with `sens_lit` = 1, increment the frame counter. If the frame counter reaches `ARM_FRAMES`, set `timeout`=1 and `result_us`=16'hFFFF, then go to HOLD.
  - **FLASH**: `lt_active`=1.
    - The prescaler counts 0..`PRESCALE`-1. On wrap, the µs counter increments, saturating at 16'hFFFF.
    - If `sens_lit` = 1: `result_us` = µs counter, `result_valid`=1, go to HOLD.
    - Otherwise, if µs counter == `TIMEOUT_US`: `timeout`=1, `result_us`=16'hFFFF, go to HOLD.
    - Sensor detection has priority over timeout in the same cycle.
  - **HOLD**: `lt_active`=0. Count `vs_fall` events; after `HOLD_FRAMES` of them, go to IDLE.
- `abort` has priority over every transition. It sends the FSM to IDLE next cycle with `lt_active`=0. `result_us`, `result_valid` and `timeout` keep their values.
- `start` asserted while `busy` is ignored, with no side effects.
- `start` and `abort` in the same cycle while in IDLE: `abort` wins and `start` is dropped.

## Timing

- Reset values:
  - `lt_active`=0, `lt_mode`=2'b00, `busy`=0.
  - `result_us`=0, `result_valid`=0, `timeout`=0.
  - FSM in IDLE; all counters 0.
- All outputs are registered.
- `lt_active` rises 1 cycle after the `vs_fall` cycle. The generator's own output register adds a further cycle.
- Measured value = floor(cycles from FLASH entry to `sens_lit` rising / `PRESCALE`). The sensor path adds 2 + `FILT_LEN` cycles, which is included in the result (not compensated).
- `result_valid`, `timeout` and `result_us` update in the same cycle that the FSM enters HOLD.
- Reset mid-FLASH: `lt_active` drops asynchronously and the result is lost.

## Structure

- Shared package/include holds:
  - state encodings (LT_ST_IDLE/ARM/FLASH/HOLD, 2 bits);
  - the existing LT_POS_* codes;
  - the 16'hFFFF error constant.
- One sub-module, `lt_sensor_filter`: synchronizer plus `FILT_LEN` glitch filter. Parameter `FILT_LEN`; ports `clk27`, `reset_n`, `sensor_n`, `sens_lit`.
- The FSM, prescaler and counters live in `lt_measure_ctrl`.

## Test plan

- **Basic measurement:** `start` with `mode_in`=LT_POS_CENTER, sensor dark, then `sensor_n` low 2700 cycles after `lt_active` rises. Expect `lt_mode`=LT_POS_CENTER, `result_us`≈100 (100 or 101 given filter delay), `result_valid`=1, `timeout`=0, IDLE after 4 further `vs_fall`.
- **FLASH timeout:** `start`, sensor never lit. Expect `timeout`=1 and `result_us`=16'hFFFF at µs count 50000; `lt_active` low the next cycle.
- **ARM timeout:** sensor held lit before `start`. Expect `timeout`=1 and `result_us`=16'hFFFF after 60 `vs_fall`; `lt_active` never asserted.
- **Glitch rejection:** 10-cycle low pulse on `sensor_n` in FLASH. Expect no detection. A later 20-cycle low pulse is detected.
- **Abort:** `abort` mid-FLASH. Expect `lt_active`=0 and `busy`=0 next cycle, previous result unchanged. `start` while `busy`: no effect.
- **Reset:** assert `reset_n` low mid-FLASH. Expect all outputs at their reset values immediately, and a clean measurement after release.
